// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive controller.
// Holds the FSM state encoding, APB register offsets, STATUS bit layout and frame geometry.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;

    localparam int ST_OVF_BIT   = 0;
    localparam int ST_FERR_BIT  = 1;
    localparam int ST_PERR_BIT  = 2;
    localparam int ST_COUNT_LSB = 8;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;
    localparam int BIT_CNT_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: single-clock FIFO with occupancy count; power-of-two DEPTH.
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 device-frame receiver with scancode FIFO and APB DATA/STATUS registers.
// Build option: define PS2_PARITY_CHECK_EN to drop frames failing odd parity and report PERR.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    input  logic        ps2_clk,
    input  logic        ps2_data
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    function automatic logic [7:0] sat8(input int unsigned v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   fall_edge;
    logic                   data_bit;

    ps2_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   push_q, push_d;
    logic                   ferr_set;

    logic                   pready_q;
    logic                   ovf_q, ferr_q;
    logic                   perr_flag;

    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;

    logic                   access, complete;
    logic                   is_data, is_status, bad_access;
    logic                   pop;
    logic                   ovf_set;
    logic [2:0]             w1c;

    // Input synchronisers: [0] is newest; idle-high reset avoids a false edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign fall_edge = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    assign data_bit  = data_sync_q[SYNC_STAGES-2];

`ifdef PS2_PARITY_CHECK_EN
    logic perr_frm_q, perr_frm_d;
    logic perr_set;
    logic perr_q;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        perr_frm_d = perr_frm_q;
        perr_set   = 1'b0;
`endif
        to_cnt_d = (fall_edge || state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;

        if (state_q != ST_IDLE && !fall_edge && to_cnt_q == TW'(TIMEOUT_CYC)) begin
            state_d  = ST_IDLE;
            ferr_set = 1'b1;
            to_cnt_d = '0;
        end else if (fall_edge) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
`ifdef PS2_PARITY_CHECK_EN
                        perr_frm_d = 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_bit, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) state_d = ST_PARITY;
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    perr_frm_d = ~(^{shift_q, data_bit});
`endif
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (!data_bit) ferr_set = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    if (perr_frm_q) perr_set = 1'b1;
                    push_d = data_bit & ~perr_frm_q;
`else
                    push_d = data_bit;
`endif
                end
            endcase
        end
    end

    assign access     = in_psel & in_penable;
    assign complete   = access & pready_q;
    assign is_data    = (in_paddr[3:2] == OFF_DATA[3:2]);
    assign is_status  = (in_paddr[3:2] == OFF_STATUS[3:2]);
    assign bad_access = (is_data & in_pwrite) | ~(is_data | is_status);
    assign pop        = complete & ~in_pwrite & is_data & ~fifo_empty;
    assign w1c        = (complete & in_pwrite & is_status) ? in_pwdata[2:0] : 3'b000;
    assign ovf_set    = push_q & fifo_full & ~pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            push_q    <= 1'b0;
            pready_q  <= 1'b0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            push_q    <= push_d;
            pready_q  <= access & ~pready_q;
            // A flag being set wins over a simultaneous write-one-to-clear.
            ovf_q     <= ovf_set  | (ovf_q  & ~w1c[ST_OVF_BIT]);
            ferr_q    <= ferr_set | (ferr_q & ~w1c[ST_FERR_BIT]);
        end
    end

    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perr_frm_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            perr_frm_q <= perr_frm_d;
            perr_q     <= perr_set | (perr_q & ~w1c[ST_PERR_BIT]);
        end
    end
    assign perr_flag = perr_q;
`else
    assign perr_flag = 1'b0;
`endif

    ps2_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push_q),
        .wdata_i (shift_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        in_prdata = '0;
        if (complete && !in_pwrite) begin
            if (is_data && !fifo_empty) begin
                in_prdata = {23'd0, 1'b1, fifo_rdata};
            end else if (is_status) begin
                in_prdata[ST_COUNT_LSB +: 8] = sat8(32'(fifo_count));
                in_prdata[ST_PERR_BIT]       = perr_flag;
                in_prdata[ST_FERR_BIT]       = ferr_q;
                in_prdata[ST_OVF_BIT]        = ovf_q;
            end
        end
    end

    assign in_pready  = pready_q;
    assign in_pslverr = complete & bad_access;

    logic unused_ok;
    assign unused_ok = ^{in_pprot, in_pstrb, in_paddr[31:4], in_paddr[1:0],
                         in_pwdata[31:3], w1c};

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb_ps2_rx_ctrl: directed-vector bench for ps2_rx_ctrl (PS/2 frames in, APB polling out).
// Expectations for the parity case follow PS2_PARITY_CHECK_EN.
`timescale 1ns/1ps
module tb_ps2_rx_ctrl;
    localparam int FIFO_DEPTH  = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 6;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    ps2_rx_ctrl #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_paddr   (paddr),
        .in_psel    (psel),
        .in_penable (penable),
        .in_pprot   (3'b000),
        .in_pwrite  (pwrite),
        .in_pwdata  (pwdata),
        .in_pstrb   (4'hF),
        .in_pready  (in_pready),
        .in_prdata  (in_prdata),
        .in_pslverr (in_pslverr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        int cyc;
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clock);
        penable = 1'b1;
        cyc = 1;
        #1;
        while (!in_pready && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        check_vec("apb_ready_cycle", cyc, 2);
        rdata = in_prdata;
        err   = in_pslverr;
        @(negedge clock);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        #1;
        check_vec("apb_ready_drop", {31'd0, in_pready}, 32'd0);
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b0, addr, 32'd0, d, e);
        check_vec(tag, d, exp);
        check_vec({tag, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b1, addr, data, d, e);
        check_vec("wr_err", {31'd0, e}, 32'd0);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_data = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
        logic par;
        par = ~^b;
        if (!par_ok) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        repeat (6) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [7:0]  b;

        // Reset state
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_vec("rst_pready",  {31'd0, in_pready},  32'd0);
        check_vec("rst_prdata",  in_prdata,           32'd0);
        check_vec("rst_pslverr", {31'd0, in_pslverr}, 32'd0);
        reset_n = 1'b1;
        rd_exp("rst_status", 32'h4, 32'h0000_0000);

        // 1: single frame, pop, empty read
        send_frame(8'h1C, 1'b1, 1'b1);
        rd_exp("t1_status", 32'h4, 32'h0000_0100);
        rd_exp("t1_data",   32'h0, 32'h0000_011C);
        rd_exp("t1_empty",  32'h0, 32'h0000_0000);
        rd_exp("t1_status0", 32'h4, 32'h0000_0000);

        // 2: overflow with nine frames
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            b = 8'h20 + 8'(i * 3);
            send_frame(b, 1'b1, 1'b1);
        end
        rd_exp("t2_status_full", 32'h4, 32'h0000_0801);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            b = 8'h20 + 8'(i * 3);
            rd_exp("t2_order", 32'h0, {23'd0, 1'b1, b});
        end
        rd_exp("t2_status_ovf", 32'h4, 32'h0000_0001);
        wr_ok(32'h4, 32'h1);
        rd_exp("t2_ovf_clr", 32'h4, 32'h0000_0000);

        // 3: bad stop bit, then a stalled frame
        send_frame(8'h55, 1'b1, 1'b0);
        rd_exp("t3_ferr_stop", 32'h4, 32'h0000_0002);
        wr_ok(32'h4, 32'h2);
        rd_exp("t3_ferr_clr", 32'h4, 32'h0000_0000);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        repeat (TIMEOUT_CYC + 50) @(negedge clock);
        rd_exp("t3_ferr_timeout", 32'h4, 32'h0000_0002);
        send_frame(8'h3A, 1'b1, 1'b1);
        rd_exp("t3_after_timeout", 32'h0, 32'h0000_013A);
        wr_ok(32'h4, 32'h2);

        // 4: 0xF0 with even parity
        send_frame(8'hF0, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        rd_exp("t4_perr", 32'h4, 32'h0000_0004);
        wr_ok(32'h4, 32'h4);
        rd_exp("t4_perr_clr", 32'h4, 32'h0000_0000);
`else
        rd_exp("t4_status", 32'h4, 32'h0000_0100);
        rd_exp("t4_data", 32'h0, 32'h0000_01F0);
`endif

        // 5: push and pop land in the same cycle on a full FIFO
        for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'h80 + 8'(i), 1'b1, 1'b1);
        rd_exp("t5_full", 32'h4, 32'h0000_0800);
        b = 8'h99;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
        @(negedge clock);
        penable = 1'b1;
        @(negedge clock);
        check_vec("t5_pready", {31'd0, in_pready}, 32'd1);
        check_vec("t5_pop", in_prdata, 32'h0000_0180);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0;
        repeat (HALF - 3) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clock);
        rd_exp("t5_status", 32'h4, 32'h0000_0800);
        for (int i = 1; i < FIFO_DEPTH; i++) rd_exp("t5_order", 32'h0, {23'd0, 1'b1, 8'h80 + 8'(i)});
        rd_exp("t5_last", 32'h0, 32'h0000_0199);

        // 6: asynchronous reset mid-frame with a buffered byte and an APB access in flight
        send_frame(8'h42, 1'b1, 1'b1);
        ps2_bit(1'b0); ps2_bit(1'b1);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
        @(negedge clock);
        penable = 1'b1;
        @(negedge clock);
        check_vec("t6_pre_pready", {31'd0, in_pready}, 32'd1);
        check_vec("t6_pre_status", in_prdata, 32'h0000_0100);
        #1 reset_n = 1'b0;
        #1;
        check_vec("t6_rst_pready",  {31'd0, in_pready},  32'd0);
        check_vec("t6_rst_prdata",  in_prdata,           32'd0);
        check_vec("t6_rst_pslverr", {31'd0, in_pslverr}, 32'd0);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        rd_exp("t6_status", 32'h4, 32'h0000_0000);
        send_frame(8'h6B, 1'b1, 1'b1);
        rd_exp("t6_data", 32'h0, 32'h0000_016B);

        // 7: decode errors leave state untouched
        send_frame(8'h5A, 1'b1, 1'b1);
        apb_xfer(1'b0, 32'h8, 32'd0, d, e);
        check_vec("t7_rd8_err",  {31'd0, e}, 32'd1);
        check_vec("t7_rd8_data", d, 32'd0);
        apb_xfer(1'b1, 32'hC, 32'hFFFF_FFFF, d, e);
        check_vec("t7_wrC_err", {31'd0, e}, 32'd1);
        apb_xfer(1'b1, 32'h0, 32'hFFFF_FFFF, d, e);
        check_vec("t7_wr0_err", {31'd0, e}, 32'd1);
        rd_exp("t7_status", 32'h4, 32'h0000_0100);
        rd_exp("t7_data", 32'h0, 32'h0000_015A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
